// File: rtl/grant_responder.sv
// grant_responder: resource-side responder for the round-robin req/grant/ack
// handshake. Accepts a one-hot grant, holds ack for the requester's service
// length, then enforces a guard gap before sampling grant again. Protocol
// violations (multi-hot grant in IDLE, grant change during service) pulse err.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a grant; sampled on every edge
// S_SERVE | ack high, servicing the latched requester
// S_GAP   | ack low, grant ignored until the arbiter has settled
module grant_responder #(
  parameter int N       = 2,
  parameter int LEN_W   = 4,
  parameter int GAP_CYC = 1,
  localparam int IDW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       grant,
  input  logic [N*LEN_W-1:0] len,
  output logic               ack,
  output logic               busy,
  output logic [IDW-1:0]     served_id,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [3:0]       GAP_LD = 4'(GAP_CYC);
  localparam logic [LEN_W-1:0] SVC_ONE = LEN_W'(1);

  state_t           state_q, state_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [IDW-1:0]   served_id_q, served_id_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [LEN_W-1:0] svc_cnt_q, svc_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;

  logic             grant_any;
  logic             grant_onehot;
  logic [IDW-1:0]   grant_idx;
  logic [LEN_W-1:0] grant_len;
  logic [LEN_W-1:0] svc_load;

  // Decode the incoming grant: validity, requester index and its length field.
  always_comb begin
    grant_idx = '0;
    grant_len = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        grant_idx = IDW'(i);
        grant_len = len[i*LEN_W +: LEN_W];
      end
    end
    grant_any    = |grant;
    grant_onehot = grant_any && ((grant & (grant - N'(1))) == '0);
    // A zero-length request still gets one cycle of service.
    svc_load     = (grant_len == '0) ? SVC_ONE : grant_len;
  end

  // Next-state and registered-output logic for the service FSM.
  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    served_id_d = served_id_q;
    grant_d     = grant_q;
    svc_cnt_d   = svc_cnt_q;
    gap_cnt_d   = gap_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        ack_d  = 1'b0;
        busy_d = 1'b0;
        if (grant_onehot) begin
          served_id_d = grant_idx;
          grant_d     = grant;
          svc_cnt_d   = svc_load;
          ack_d       = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_SERVE;
        end else if (grant_any) begin
          err_d = 1'b1;
        end
      end

      S_SERVE: begin
        svc_cnt_d = svc_cnt_q - SVC_ONE;
        // A withdrawn or moved grant wins over a completion on the same edge.
        if (grant != grant_q) begin
          ack_d     = 1'b0;
          err_d     = 1'b1;
          gap_cnt_d = GAP_LD;
          state_d   = S_GAP;
        end else if (svc_cnt_q == SVC_ONE) begin
          ack_d     = 1'b0;
          done_d    = 1'b1;
          gap_cnt_d = GAP_LD;
          state_d   = S_GAP;
        end
      end

      S_GAP: begin
        ack_d     = 1'b0;
        gap_cnt_d = gap_cnt_q - 4'd1;
        if (gap_cnt_q == 4'd1) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      served_id_q <= '0;
      grant_q     <= '0;
      svc_cnt_q   <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      served_id_q <= served_id_d;
      grant_q     <= grant_d;
      svc_cnt_q   <= svc_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign served_id = served_id_q;

endmodule

// File: tb/tb_grant_responder.sv
// Testbench for grant_responder: directed scenarios plus randomized grant/len
// traffic, every cycle compared against a transaction-level reference model.
module tb_grant_responder;

  localparam int N       = 2;
  localparam int LEN_W   = 4;
  localparam int GAP_CYC = 1;
  localparam int IDW     = 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N-1:0]       grant = '0;
  logic [N*LEN_W-1:0] len = '0;
  logic               ack, busy, done, err;
  logic [IDW-1:0]     served_id;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: remaining ack-high cycles and remaining guard cycles.
  logic       e_ack, e_busy, e_done, e_err;
  int         e_id;
  logic [N-1:0] m_grant;
  int         m_left, m_gap;

  grant_responder #(.N(N), .LEN_W(LEN_W), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .grant(grant), .len(len),
    .ack(ack), .busy(busy), .served_id(served_id), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_ack = 0; e_busy = 0; e_done = 0; e_err = 0; e_id = 0;
    m_grant = '0; m_left = 0; m_gap = 0;
  endtask

  // Advance the reference by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    int l;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_done = 0;
    e_err  = 0;
    if (m_left > 0) begin
      if (grant != m_grant) begin
        e_ack = 0; e_err = 1; m_left = 0; m_gap = GAP_CYC;
      end else begin
        m_left--;
        if (m_left == 0) begin
          e_ack = 0; e_done = 1; m_gap = GAP_CYC;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) e_busy = 0;
    end else if ($countones(grant) == 1) begin
      l = 0;
      for (int i = 0; i < N; i++)
        if (grant[i]) begin
          e_id = i;
          l = int'(len[i*LEN_W +: LEN_W]);
        end
      m_left  = (l == 0) ? 1 : l;
      m_grant = grant;
      e_ack = 1; e_busy = 1;
    end else if (grant != '0) begin
      e_err = 1;
    end
  endtask

  task automatic check_all();
    chk("ack", 32'(ack), 32'(e_ack));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    chk("served_id", 32'(served_id), 32'(e_id));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic settle_idle();
    grant = '0;
    repeat (GAP_CYC + 3) cycle();
  endtask

  initial begin
    int ptr, hi_len, n_done, n_srv, budget, cnt;
    int srv_id[$];
    int srv_len[$];
    logic prev_ack;

    model_reset();

    // Reset held with a pending grant, then released.
    rst_n = 0;
    grant = 2'b01;
    len   = 8'h23;
    #1;
    check_all();
    repeat (3) cycle();
    rst_n = 1;
    cycle();
    chk("ack_after_release", 32'(ack), 32'd1);
    repeat (8) cycle();
    settle_idle();

    // Arbiter model: both requesting, pointer advances on ack falling.
    ptr = 0; hi_len = 0; n_done = 0; prev_ack = 0; budget = 0;
    len = 8'h23;
    grant = 2'b01;
    while (srv_len.size() < 4 && budget < 200) begin
      cycle();
      budget++;
      if (done) n_done++;
      if (ack) hi_len++;
      if (prev_ack && !ack) begin
        srv_id.push_back(int'(served_id));
        srv_len.push_back(hi_len);
        hi_len = 0;
        ptr = 1 - ptr;
        grant = (ptr == 0) ? 2'b01 : 2'b10;
      end
      prev_ack = ack;
    end
    chk("alt_services", 32'(srv_len.size()), 32'd4);
    for (int i = 0; i < srv_len.size(); i++) begin
      chk("alt_id", 32'(srv_id[i]), 32'(i % 2));
      chk("alt_len", 32'(srv_len[i]), (i % 2 == 0) ? 32'd3 : 32'd2);
    end
    chk("alt_done_count", 32'(n_done), 32'd4);
    settle_idle();

    // Zero-length request for requester 1.
    len = 8'h03;
    grant = 2'b10;
    cnt = 0; n_done = 0;
    repeat (6) begin
      cycle();
      if (ack) cnt++;
      if (done) n_done++;
    end
    chk("zero_len_ack_cycles", 32'(cnt), 32'd2);
    chk("zero_len_done", 32'(n_done), 32'd2);
    settle_idle();

    // Multi-hot grant in IDLE: err every edge, never ack.
    grant = 2'b11;
    repeat (5) begin
      cycle();
      chk("multihot_err", 32'(err), 32'd1);
      chk("multihot_ack", 32'(ack), 32'd0);
    end
    settle_idle();

    // Grant moves on the second SERVE cycle: abort.
    len = 8'h05;
    grant = 2'b01;
    cycle();
    chk("abort_ack_rise", 32'(ack), 32'd1);
    cycle();
    grant = 2'b10;
    cycle();
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_err", 32'(err), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    settle_idle();

    // Asynchronous reset in the middle of a service.
    len = 8'h25;
    grant = 2'b01;
    repeat (2) cycle();
    chk("pre_reset_ack", 32'(ack), 32'd1);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("async_reset_ack", 32'(ack), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    grant = 2'b10;
    repeat (2) cycle();
    rst_n = 1;
    cnt = 0;
    repeat (6) begin
      cycle();
      if (ack) cnt++;
    end
    chk("post_reset_ack_cycles", 32'(cnt), 32'd4);
    settle_idle();

    // Randomized grant/len traffic.
    for (int k = 0; k < 600; k++) begin
      int r;
      r = $urandom_range(0, 11);
      case (r)
        7: grant = 2'b00;
        8, 9: grant = 2'b01;
        10: grant = 2'b10;
        11: grant = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b10;
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) len = 8'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
